// File: rtl/i2c_rd16_scheduler.sv
`timescale 1ns/1ps
// Round-robin front end that shares one I2C 2-byte read engine among N_REQ requesters.
// Sequences GO/END_OK, keeps ACK sticky, retries NACKs and resets a hung engine on timeout.
module i2c_rd16_scheduler #(
  parameter int N_REQ     = 4,
  parameter int GO_HOLD   = 4,
  parameter int TIMEOUT   = 4095,
  parameter int RETRY_MAX = 2
) (
  input  logic               i_pt_ck,
  input  logic               i_reset,
  input  logic [N_REQ-1:0]   i_req,
  input  logic [8*N_REQ-1:0] i_req_addr,
  output logic [N_REQ-1:0]   o_gnt,
  output logic [N_REQ-1:0]   o_done,
  output logic [15:0]        o_rd_data,
  output logic               o_rd_err,
  output logic               o_busy,
  output logic               o_i2c_go,
  output logic [7:0]         o_i2c_slave_addr,
  output logic               o_i2c_reset_n,
  input  logic               i_i2c_end_ok,
  input  logic               i_i2c_ack_ok,
  input  logic [15:0]        i_i2c_data16,
  output logic [2:0]         o_dbg_state
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int GW = $clog2(GO_HOLD);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ISSUE    = 3'd1;
  localparam logic [2:0] ST_RELEASE  = 3'd2;
  localparam logic [2:0] ST_WAIT     = 3'd3;
  localparam logic [2:0] ST_COMPLETE = 3'd4;
  localparam logic [2:0] ST_ENG_RST  = 3'd5;
  localparam logic [2:0] ST_RECOVER  = 3'd6;
  localparam logic [2:0] ST_DONE     = 3'd7;

  logic [2:0]       r_state;
  logic [N_REQ-1:0] r_gnt;
  logic [N_REQ-1:0] r_done;
  logic [IW-1:0]    r_gnt_idx;
  logic [IW-1:0]    r_rr_ptr;
  logic [15:0]      r_rd_data;
  logic             r_rd_err;
  logic             r_go;
  logic [7:0]       r_slave_addr;
  logic             r_eng_rst_n;
  logic [GW-1:0]    r_go_cnt;
  logic [TW-1:0]    r_to_cnt;
  logic [RW-1:0]    r_retry;
  logic             r_ack_seen;
  logic             r_rst_cnt;

  logic             w_pick_valid;
  logic [IW-1:0]    w_pick_idx;
  logic [7:0]       w_pick_addr;
  logic [TW-1:0]    w_to_next;
  logic             w_to_expired;

  // Lowest offset from the rr pointer wins; the downward loop lets it overwrite later hits.
  always_comb begin
    w_pick_valid = 1'b0;
    w_pick_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (i_req[IW'((int'(r_rr_ptr) + k) % N_REQ)]) begin
        w_pick_valid = 1'b1;
        w_pick_idx   = IW'((int'(r_rr_ptr) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    w_pick_addr = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_pick_idx == IW'(k)) w_pick_addr = i_req_addr[8*k +: 8];
    end
  end

  assign w_to_next    = r_to_cnt + 1'b1;
  assign w_to_expired = (w_to_next == TW'(TIMEOUT));

  always_ff @(posedge i_pt_ck or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_gnt        <= '0;
      r_done       <= '0;
      r_gnt_idx    <= '0;
      r_rr_ptr     <= '0;
      r_rd_data    <= '0;
      r_rd_err     <= 1'b0;
      r_go         <= 1'b0;
      r_slave_addr <= '0;
      r_eng_rst_n  <= 1'b1;
      r_go_cnt     <= '0;
      r_to_cnt     <= '0;
      r_retry      <= '0;
      r_ack_seen   <= 1'b0;
      r_rst_cnt    <= 1'b0;
    end else begin
      r_done <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_pick_valid) begin
            r_gnt             <= '0;
            r_gnt[w_pick_idx] <= 1'b1;
            r_gnt_idx         <= w_pick_idx;
            r_slave_addr      <= w_pick_addr;
            r_retry           <= '0;
            r_go              <= 1'b1;
            r_go_cnt          <= '0;
            r_state           <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_ack_seen <= 1'b0;
          if (r_go_cnt == GW'(GO_HOLD - 1)) begin
            r_go     <= 1'b0;
            r_to_cnt <= '0;
            r_state  <= ST_RELEASE;
          end else begin
            r_go_cnt <= r_go_cnt + 1'b1;
          end
        end
        ST_RELEASE: begin
          r_to_cnt <= w_to_next;
          if (!i_i2c_end_ok) begin
            r_state <= ST_WAIT;
          end else if (w_to_expired) begin
            r_eng_rst_n <= 1'b0;
            r_rst_cnt   <= 1'b0;
            r_state     <= ST_ENG_RST;
          end
        end
        ST_WAIT: begin
          r_to_cnt <= w_to_next;
          // The engine drops ACK_OK the cycle END_OK rises, so remember any ACK seen.
          r_ack_seen <= r_ack_seen | i_i2c_ack_ok;
          if (i_i2c_end_ok) begin
            r_state <= ST_COMPLETE;
          end else if (w_to_expired) begin
            r_eng_rst_n <= 1'b0;
            r_rst_cnt   <= 1'b0;
            r_state     <= ST_ENG_RST;
          end
        end
        ST_COMPLETE: begin
          if (r_ack_seen) begin
            r_rd_data <= i_i2c_data16;
            r_rd_err  <= 1'b0;
            r_done    <= r_gnt;
            r_state   <= ST_DONE;
          end else if (r_retry < RW'(RETRY_MAX)) begin
            r_retry  <= r_retry + 1'b1;
            r_go     <= 1'b1;
            r_go_cnt <= '0;
            r_state  <= ST_ISSUE;
          end else begin
            r_rd_err <= 1'b1;
            r_done   <= r_gnt;
            r_state  <= ST_DONE;
          end
        end
        ST_ENG_RST: begin
          if (r_rst_cnt) begin
            r_eng_rst_n <= 1'b1;
            r_to_cnt    <= '0;
            r_state     <= ST_RECOVER;
          end else begin
            r_rst_cnt <= 1'b1;
          end
        end
        ST_RECOVER: begin
          r_to_cnt <= w_to_next;
          if (i_i2c_end_ok || w_to_expired) begin
            r_rd_err <= 1'b1;
            r_done   <= r_gnt;
            r_state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_gnt <= '0;
          if (r_gnt_idx == IW'(N_REQ - 1)) r_rr_ptr <= '0;
          else                             r_rr_ptr <= r_gnt_idx + 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_gnt            = r_gnt;
  assign o_done           = r_done;
  assign o_rd_data        = r_rd_data;
  assign o_rd_err         = r_rd_err;
  assign o_busy           = (r_state != ST_IDLE);
  assign o_i2c_go         = r_go;
  assign o_i2c_slave_addr = r_slave_addr;
  assign o_i2c_reset_n    = r_eng_rst_n;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_i2c_rd16_scheduler.sv
`timescale 1ns/1ps
// Directed bench for i2c_rd16_scheduler with a small behavioural I2C read engine.
module tb_i2c_rd16_scheduler;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [8*N-1:0] req_addr;
  logic [N-1:0] gnt, done;
  logic [15:0]  rd_data;
  logic         rd_err, busy, go, rstn;
  logic [7:0]   slave_addr;
  logic         end_ok, ack_ok;
  logic [15:0]  data16;
  logic [2:0]   dbg_state;

  i2c_rd16_scheduler #(.N_REQ(N), .GO_HOLD(4), .TIMEOUT(4095), .RETRY_MAX(2)) dut (
    .i_pt_ck(clk), .i_reset(rst), .i_req(req), .i_req_addr(req_addr),
    .o_gnt(gnt), .o_done(done), .o_rd_data(rd_data), .o_rd_err(rd_err),
    .o_busy(busy), .o_i2c_go(go), .o_i2c_slave_addr(slave_addr),
    .o_i2c_reset_n(rstn), .i_i2c_end_ok(end_ok), .i_i2c_ack_ok(ack_ok),
    .i_i2c_data16(data16), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Engine model knobs and observations
  int          eng_st = 0, eng_cnt = 0, eng_nacks_left = 0;
  bit          eng_hang = 0, eng_use_addr = 0;
  logic [15:0] eng_data = '0;
  bit          go_q = 0;
  int          go_pulses = 0, cur_go_len = 0, last_go_len = 0;

  initial begin
    end_ok = 1'b1; ack_ok = 1'b0; data16 = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        eng_st = 0; end_ok = 1'b1; ack_ok = 1'b0; go_q = 0;
        continue;
      end
      if (go && !go_q) begin go_pulses++; cur_go_len = 1; end
      else if (go) cur_go_len++;
      if (!go && go_q) begin
        last_go_len = cur_go_len; eng_st = 1; eng_cnt = 2;
      end else begin
        case (eng_st)
          1: begin
            eng_cnt--;
            if (eng_cnt == 0) begin
              end_ok = 1'b0;
              if (eng_hang) eng_st = 3;
              else begin eng_st = 2; eng_cnt = 3; ack_ok = (eng_nacks_left == 0); end
            end
          end
          2: begin
            eng_cnt--;
            if (eng_cnt == 0) begin
              end_ok = 1'b1; ack_ok = 1'b0;
              if (eng_nacks_left == 0) data16 = eng_use_addr ? {slave_addr, ~slave_addr} : eng_data;
              else begin eng_nacks_left--; data16 = 16'hDEAD; end
              eng_st = 0;
            end
          end
          3: if (!rstn) begin end_ok = 1'b1; eng_st = 0; end
          default: ;
        endcase
      end
      go_q = go;
    end
  end

  // Protocol monitor
  bit twohot_seen = 0, done_bad = 0, to_run = 0;
  int done_cnt = 0, rstn_low = 0, to_meas = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (!$onehot0(gnt)) twohot_seen = 1;
        if (done != '0 && done !== gnt) done_bad = 1;
        if (done != '0) done_cnt++;
        if (!rstn) rstn_low++;
        if (go) begin to_meas = 0; to_run = 1; end
        else if (!rstn) to_run = 0;
        else if (to_run) to_meas++;
      end
    end
  end

  task automatic wait_done(input string tag, input int budget,
                           output logic [N-1:0] d, output logic [15:0] dat, output logic e);
    d = '0; dat = '0; e = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done != '0) begin d = done; dat = rd_data; e = rd_err; return; end
    end
    chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic apply_reset();
    rst = 1'b1; req = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  logic [N-1:0] d;
  logic [15:0]  dat;
  logic         e;
  logic [1:0]   exp_q[$];
  logic [1:0]   exp_idx;
  logic [15:0]  exp_data2 [4] = '{16'h18E7, 16'h11EE, 16'h12ED, 16'h13EC};

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = '0;
    req_addr = {8'h13, 8'h12, 8'h11, 8'h18};
    repeat (2) @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_err", rd_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_go", go, 0);
    chk("rst_addr", slave_addr, 0);
    chk("rst_rstn", rstn, 1);
    chk("rst_state", dbg_state, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: single ACKed read
    eng_data = 16'hA55A; go_pulses = 0;
    req = 4'b0001;
    @(negedge clk);
    chk("t1_gnt", gnt, 4'b0001);
    chk("t1_addr", slave_addr, 8'h18);
    chk("t1_go", go, 1);
    chk("t1_busy", busy, 1);
    wait_done("t1", 200, d, dat, e);
    req = '0;
    chk("t1_done", d, 4'b0001);
    chk("t1_data", dat, 16'hA55A);
    chk("t1_err", e, 0);
    chk("t1_go_pulses", go_pulses, 1);
    chk("t1_go_len", last_go_len, 4);
    @(negedge clk);
    chk("t1_gnt_clr", gnt, 0);
    chk("t1_idle", busy, 0);

    // 2: all four requesting, round robin from a fresh pointer
    apply_reset();
    twohot_seen = 0; done_bad = 0; done_cnt = 0; eng_use_addr = 1;
    exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
    exp_q.push_back(2'd3); exp_q.push_back(2'd0);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_done("t2", 300, d, dat, e);
      exp_idx = exp_q.pop_front();
      chk("t2_done", d, 4'b0001 << exp_idx);
      chk("t2_data", dat, exp_data2[exp_idx]);
      chk("t2_err", e, 0);
    end
    req = '0;
    repeat (3) @(negedge clk);
    chk("t2_twohot", twohot_seen, 0);
    chk("t2_done_gnt", done_bad, 0);
    chk("t2_done_cnt", done_cnt, 5);
    eng_use_addr = 0;

    // 3: two NACKs then ACK
    eng_nacks_left = 2; eng_data = 16'h1234; go_pulses = 0;
    req = 4'b0100;
    wait_done("t3", 400, d, dat, e);
    req = '0;
    chk("t3_done", d, 4'b0100);
    chk("t3_data", dat, 16'h1234);
    chk("t3_err", e, 0);
    chk("t3_go_pulses", go_pulses, 3);
    repeat (2) @(negedge clk);

    // 4: NACK forever, data must hold the previous result
    eng_nacks_left = 99; go_pulses = 0;
    req = 4'b1000;
    wait_done("t4", 400, d, dat, e);
    req = '0;
    chk("t4_done", d, 4'b1000);
    chk("t4_data", dat, 16'h1234);
    chk("t4_err", e, 1);
    chk("t4_go_pulses", go_pulses, 3);
    eng_nacks_left = 0;
    repeat (2) @(negedge clk);

    // 5: hung engine, timeout and engine reset
    eng_hang = 1; rstn_low = 0; go_pulses = 0;
    req = 4'b0001;
    wait_done("t5", 5000, d, dat, e);
    req = '0;
    chk("t5_done", d, 4'b0001);
    chk("t5_err", e, 1);
    chk("t5_data", dat, 16'h1234);
    chk("t5_rstn_low", rstn_low, 2);
    chk("t5_timeout_len", to_meas, 4095);
    chk("t5_go_pulses", go_pulses, 1);
    eng_hang = 0;
    repeat (2) @(negedge clk);
    eng_data = 16'hBEEF;
    req = 4'b0010;
    wait_done("t5b", 200, d, dat, e);
    req = '0;
    chk("t5b_done", d, 4'b0010);
    chk("t5b_data", dat, 16'hBEEF);
    chk("t5b_err", e, 0);
    repeat (2) @(negedge clk);

    // 6: reset while waiting for the engine
    eng_hang = 1;
    req = 4'b0001;
    for (int i = 0; i < 100 && eng_st != 3; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("t6_pre_busy", busy, 1);
    chk("t6_pre_gnt", gnt, 4'b0001);
    chk("t6_pre_state", dbg_state, 3);
    rst = 1'b1;
    #1;
    chk("t6_gnt", gnt, 0);
    chk("t6_go", go, 0);
    chk("t6_busy", busy, 0);
    chk("t6_rstn", rstn, 1);
    chk("t6_addr", slave_addr, 0);
    @(negedge clk);
    req = '0; eng_hang = 0; rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_idle_state", dbg_state, 0);
    chk("t6_idle_busy", busy, 0);
    eng_data = 16'h0F0F;
    req = 4'b0001;
    wait_done("t6b", 200, d, dat, e);
    req = '0;
    chk("t6b_done", d, 4'b0001);
    chk("t6b_data", dat, 16'h0F0F);
    chk("t6b_err", e, 0);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
